// File: rtl/imem_prefetch.sv
// Two-entry instruction line buffer with demand fill and next-line prefetch.
// Each entry holds one memory word (two instructions). Lookups are
// combinational. A miss costs two cycles: issue the read, then capture the data.
// Writes to instruction memory are snooped so that stale lines are dropped.
module imem_prefetch #(
  parameter int i_width     = 20,
  parameter int i_adr_width = 10
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic [i_adr_width-1:0]   pc,
  input  logic                     jump,
  output logic [i_width-1:0]       instruction,
  output logic                     instr_valid,
  output logic                     mem_rd,
  output logic [i_adr_width-2:0]   mem_adr,
  input  logic [2*i_width-1:0]     mem_data,
  input  logic                     imem_write,
  input  logic [i_adr_width-1:0]   imem_write_adr
);

  localparam int word_w = i_adr_width - 1;

  typedef enum logic [1:0] {IDLE, DEMAND, PREF} state_t;

  state_t                state_reg;
  state_t                state_next;
  logic [1:0]            valid_reg;
  logic [word_w-1:0]     tag_reg [2];
  logic [2*i_width-1:0]  data_reg [2];
  logic                  lru_reg;
  logic [word_w-1:0]     pend_adr_reg;
  logic                  pend_entry_reg;

  logic [word_w-1:0]     pc_word;
  logic [word_w-1:0]     next_word;
  logic [word_w-1:0]     wr_word;
  logic [1:0]            entry_hit;
  logic [1:0]            entry_next;
  logic [1:0]            snoop_hit;
  logic                  wr_pc;
  logic                  wr_next;
  logic                  wr_pend;
  logic                  hit;
  logic                  hit_idx;
  logic                  demand_rd;
  logic                  pref_rd;
  logic                  demand_victim;

  assign pc_word   = pc[i_adr_width-1:1];
  assign next_word = pc_word + 1'b1;  // wraps naturally at the top of memory
  assign wr_word   = imem_write_adr[i_adr_width-1:1];

  // Per-entry tag compares against the current word, the following word and the snooped word
  generate
    for (genvar gi = 0; gi < 2; gi++) begin : g_cmp
      assign entry_hit[gi]  = valid_reg[gi] && (tag_reg[gi] == pc_word);
      assign entry_next[gi] = valid_reg[gi] && (tag_reg[gi] == next_word);
      assign snoop_hit[gi]  = imem_write && (tag_reg[gi] == wr_word);
    end
  endgenerate

  assign wr_pc   = imem_write && (wr_word == pc_word);
  assign wr_next = imem_write && (wr_word == next_word);
  assign wr_pend = imem_write && (wr_word == pend_adr_reg);

  // A write to the requested word in the same cycle hides the hit; the line is stale
  assign hit     = reset && (|entry_hit) && !wr_pc;
  assign hit_idx = !entry_hit[0];

  // Reads are only launched from IDLE; a demand read waits out a same-cycle write
  assign demand_rd = reset && (state_reg == IDLE) && !hit && !wr_pc;
  assign pref_rd   = hit && (state_reg == IDLE) && !jump && !(|entry_next) && !wr_next;

  // Fill an empty entry first (entry 0 preferred), otherwise replace the LRU choice
  assign demand_victim = !valid_reg[0] ? 1'b0 : (!valid_reg[1] ? 1'b1 : lru_reg);

  // Output selection and next-state decode
  always_comb begin
    instr_valid = 1'b0;
    instruction = '0;
    mem_rd      = 1'b0;
    mem_adr     = '0;
    state_next  = IDLE;
    if (hit) begin
      instr_valid = 1'b1;
      instruction = pc[0] ? data_reg[hit_idx][2*i_width-1:i_width]
                          : data_reg[hit_idx][i_width-1:0];
    end
    if (demand_rd) begin
      mem_rd  = 1'b1;
      mem_adr = pc_word;
    end else if (pref_rd) begin
      mem_rd  = 1'b1;
      mem_adr = next_word;
    end
    case (state_reg)
      IDLE:    state_next = demand_rd ? DEMAND : (pref_rd ? PREF : IDLE);
      default: state_next = IDLE;
    endcase
  end

  // FSM, valid bits, LRU and the outstanding-read bookkeeping
  always_ff @(posedge clk) begin
    if (!reset) begin
      state_reg <= IDLE;
      valid_reg <= 2'b00;
      lru_reg   <= 1'b0;
    end else begin
      state_reg <= state_next;
      if (hit) begin
        lru_reg <= ~hit_idx;
      end
      for (int i = 0; i < 2; i++) begin
        if (snoop_hit[i]) begin
          valid_reg[i] <= 1'b0;
        end
      end
      // The fill overrides the snoop clear for its own entry; a write to the
      // word in flight means the returned data is already stale
      if (state_reg != IDLE) begin
        valid_reg[pend_entry_reg] <= !wr_pend;
      end
      if (mem_rd) begin
        pend_adr_reg   <= mem_adr;
        pend_entry_reg <= demand_rd ? demand_victim : ~hit_idx;
      end
    end
  end

  // Line payload and tag capture; validity is tracked separately
  always_ff @(posedge clk) begin
    if (reset && (state_reg != IDLE)) begin
      data_reg[pend_entry_reg] <= mem_data;
      tag_reg[pend_entry_reg]  <= pend_adr_reg;
    end
  end

endmodule

// File: doc/imem_prefetch.md
IMEM_PREFETCH -- requirements
Module: imem_prefetch

Interface
REQ-001 SHALL have parameter i_width, default 20, instruction width in bits.
REQ-002 SHALL have parameter i_adr_width, default 10, instruction address width; memory word address width = i_adr_width-1.
REQ-003 SHALL have port clk  input  1  the single clock; all state changes on its rising edge.
REQ-004 SHALL have port reset  input  1  synchronous, active-low reset.
REQ-005 SHALL have port pc  input  i_adr_width  instruction address requested by pat; word = pc[9:1], half = pc[0].
REQ-006 SHALL have port jump  input  1  pc is a branch target this cycle.
REQ-007 SHALL have port instruction  output  i_width  fetched instruction; 0 when instr_valid=0.
REQ-008 SHALL have port instr_valid  output  1  instruction valid for the current pc.
REQ-009 SHALL have port mem_rd  output  1  read strobe to instruction memory; combinational.
REQ-010 SHALL have port mem_adr  output  i_adr_width-1  memory word address; combinational; 0 when mem_rd=0.
REQ-011 SHALL have port mem_data  input  2*i_width  read data, valid in the cycle after mem_rd.
REQ-012 SHALL have port imem_write  input  1  instruction memory write strobe (coherency snoop).
REQ-013 SHALL have port imem_write_adr  input  i_adr_width  write address; snooped word = imem_write_adr[9:1].

Function
REQ-014 SHALL hold 2 line entries, each {valid, tag[8:0], data[39:0]}, plus 1 LRU bit and FSM state.
REQ-015 SHALL flag a hit when a valid entry tag equals pc[9:1] and no write hits that word this cycle.
REQ-016 On a hit, SHALL set instr_valid=1 combinationally; instruction = data[19:0] if pc[0]=0, else data[39:20].
REQ-017 SHALL use FSM states IDLE, DEMAND, PREF; IDLE->DEMAND on demand read, IDLE->PREF on prefetch read, DEMAND/PREF->IDLE unconditionally after one cycle.
REQ-018 SHALL issue mem_rd only in IDLE; DEMAND and PREF never issue a read.
REQ-019 Demand read: in IDLE on a miss with no write to pc[9:1] this cycle, SHALL set mem_rd=1 with mem_adr=pc[9:1].
REQ-020 Prefetch read: in IDLE on a hit to word T with jump=0, when no valid entry has tag T+1 mod 512 and no write hits T+1, SHALL set mem_rd=1 with mem_adr=T+1 mod 512.
REQ-021 SHALL write returned mem_data into the target entry at the end of the DEMAND/PREF cycle; set valid=1 and tag=issued address.
REQ-022 Demand victim: the first invalid entry, entry 0 first; else the entry selected by the LRU bit.
REQ-023 Prefetch victim: the entry not holding word T.
REQ-024 On every hit, SHALL set the LRU bit to select the other entry.
REQ-025 Miss penalty: exactly 2 cycles (miss in cycle c, hit in c+2); a sequential stream after the first fill SHALL not stall.
REQ-026 A miss in DEMAND/PREF SHALL wait; after the fill it is re-evaluated in IDLE, with no duplicate read if the fill matches.
REQ-027 On imem_write, SHALL clear valid of any entry whose tag equals the snooped word, at the same edge.
REQ-028 If the snooped word equals the outstanding read address, SHALL discard the returned data; the entry stays invalid.
REQ-029 A write to pc[9:1] in the same cycle SHALL force instr_valid=0 and suppress the demand read; the read is issued next cycle.
REQ-030 jump=1 SHALL suppress the prefetch only; an outstanding prefetch completes and is written.

Reset
REQ-031 While reset=0 at a clock edge, SHALL clear both valid bits, set the LRU bit to 0 and the FSM to IDLE.
REQ-032 Reset during DEMAND/PREF SHALL discard the outstanding returned data.
REQ-033 During and after reset, until the first fill: instr_valid=0, instruction=0; mem_rd=0 and mem_adr=0 while reset=0.

Verification
REQ-034 Reset released, pc=0 held -> cycle0 mem_rd=1 adr=0; cycle1 no rd; cycle2 instr_valid=1 with instruction=mem_data[19:0] of word 0, and prefetch adr=1.
REQ-035 pc=0,1,2,3,4 on successive cycles after the first fill -> instr_valid=1 every cycle; prefetch adrs 1, 2 issued on the word-entry cycles.
REQ-036 Warm buffer, jump=1 to pc=0x3F0 -> mem_rd=1 adr=0x1F8; no prefetch that cycle; hit 2 cycles later; pc=0x3FF prefetches adr 0 (wrap).
REQ-037 imem_write to word 5 while word 5 is buffered and pc=10 -> instr_valid=0, no read that cycle; adr=5 read next cycle; new data served 2 cycles later.
REQ-038 Write to word 6 during a PREF of word 6 -> returned data discarded; pc=12 then misses and re-reads adr 6.
REQ-039 reset=0 asserted in a DEMAND cycle -> no entry written; after release, pc re-misses with mem_rd=1.
